// File: rtl/dataout_buf_pkg.sv
// ---------------------------------------------------------------------------
// dataout_buf_pkg
// Shared flit layout and transmit-FSM encoding for the dataout buffer and
// any sink buffers that consume its flits.
//   FLIT_W          : full flit width
//   PAYLOAD_MSB/LSB : payload field bounds inside a flit
//   DEST_MSB/LSB    : destination/control field bounds inside a flit
//   state_t         : transmit FSM state encoding
// ---------------------------------------------------------------------------
package dataout_buf_pkg;

  localparam int FLIT_W      = 20;
  localparam int PAYLOAD_MSB = 19;
  localparam int PAYLOAD_LSB = 4;
  localparam int DEST_MSB    = 3;
  localparam int DEST_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/flit_ram.sv
// ---------------------------------------------------------------------------
// flit_ram
// DEPTH x FLIT_W flit store with one write port and one synchronous read
// port. The read register updates every cycle from raddr.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write flit
//   raddr : read address, sampled on posedge clk
//   rdata : registered read flit
// ---------------------------------------------------------------------------
module flit_ram
  import dataout_buf_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FLIT_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FLIT_W-1:0] rdata
);

  logic [FLIT_W-1:0] mem [DEPTH];

  // Write-first bypass: a flit written to the address being read is
  // forwarded, so a start right after loading entry 0 sees the new flit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dataout_buf.sv
// ---------------------------------------------------------------------------
// dataout_buf
// Loads a batch of flits into a local store, then on start streams them out
// over a valid/ready interface, optionally inserting GAP idle cycles after
// each accepted flit. The batch is retained so a later start replays it.
//   clk       : clock
//   rst       : synchronous active-low reset
//   wr_en     : load strobe (IDLE/DONE only)
//   wr_data   : flit to load, [19:4] payload, [3:0] destination/control
//   clr       : empties the store count, returns to IDLE
//   start     : begins transmission of all loaded flits
//   out_ready : downstream accept
//   out_valid : dataout holds a flit
//   dataout   : registered output flit
//   busy      : transmitting (SEND or GAP)
//   done      : batch complete (DONE)
//   sent      : flits accepted in the current run
// ---------------------------------------------------------------------------
module dataout_buf
  import dataout_buf_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int GAP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              clr,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic [7:0]        sent
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L  = 9'(DEPTH);
  localparam logic [7:0] GAP_INIT = 8'((GAP > 0) ? GAP - 1 : 0);

  state_t            state;
  logic [7:0]        load_cnt;
  logic [7:0]        rd_ptr;
  logic [7:0]        gap_cnt;
  logic              idle_like;
  logic              handshake;
  logic              last_flit;
  logic              start_go;
  logic              load_go;
  logic [AW-1:0]     rd_addr;
  logic [FLIT_W-1:0] rd_data;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign out_valid = (state == ST_SEND);
  assign busy      = (state == ST_SEND) || (state == ST_GAP);
  assign done      = (state == ST_DONE);
  assign handshake = out_valid && out_ready;
  assign last_flit = ((sent + 8'd1) == load_cnt);

  // clr beats start beats wr_en; the losers are simply dropped.
  assign start_go = idle_like && !clr && start && (load_cnt != 8'd0);
  assign load_go  = idle_like && !clr && !start && wr_en &&
                    ({1'b0, load_cnt} < DEPTH_L);

  // The RAM read register always holds the flit that dataout will take at
  // the next load point: mem[0] while parked, mem[rd_ptr] while sending.
  // The address therefore tracks the value rd_ptr will have after this edge.
  always_comb begin
    rd_addr = '0;
    if (rst) begin
      if (state == ST_SEND) begin
        if (!handshake) begin
          rd_addr = AW'(rd_ptr);
        end else if (!last_flit) begin
          rd_addr = AW'(rd_ptr + 8'd1);
        end
      end else if (state == ST_GAP) begin
        rd_addr = AW'(rd_ptr);
      end else if (start_go) begin
        rd_addr = AW'(8'd1);
      end
    end
  end

  flit_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (load_go),
    .waddr (AW'(load_cnt)),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Transmit FSM with its counters and the output flit register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      load_cnt <= 8'd0;
      rd_ptr   <= 8'd0;
      gap_cnt  <= 8'd0;
      sent     <= 8'd0;
      dataout  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (clr) begin
            load_cnt <= 8'd0;
            state    <= ST_IDLE;
          end else if (start_go) begin
            state   <= ST_SEND;
            dataout <= rd_data;
            rd_ptr  <= 8'd1;
            sent    <= 8'd0;
          end else if (load_go) begin
            load_cnt <= load_cnt + 8'd1;
          end
        end
        ST_SEND: begin
          if (handshake) begin
            sent <= sent + 8'd1;
            if (last_flit) begin
              state <= ST_DONE;
            end else begin
              dataout <= rd_data;
              rd_ptr  <= rd_ptr + 8'd1;
              if (GAP > 0) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_INIT;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dataout_buf.sv
// ---------------------------------------------------------------------------
// tb_dataout_buf
// Drives two dataout_buf instances (GAP=0 and GAP=2) from shared inputs and
// compares every cycle against a queue-style behavioural model, plus a
// table of hand-computed vectors and directed multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_dataout_buf;
  import dataout_buf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, wr_en, clr, start, out_ready;
  logic [FLIT_W-1:0] wr_data;
  logic              ov   [2];
  logic [FLIT_W-1:0] dout [2];
  logic              bsy  [2];
  logic              dn   [2];
  logic [7:0]        snt  [2];

  dataout_buf #(.DEPTH(128), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .out_ready(out_ready), .out_valid(ov[0]),
    .dataout(dout[0]), .busy(bsy[0]), .done(dn[0]), .sent(snt[0])
  );

  dataout_buf #(.DEPTH(128), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .out_ready(out_ready), .out_valid(ov[1]),
    .dataout(dout[1]), .busy(bsy[1]), .done(dn[1]), .sent(snt[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a flit list, a cursor, a countdown of idle cycles.
  logic [FLIT_W-1:0] m_store [2][256];
  int                m_cnt  [2];
  int                m_pos  [2];
  int                m_gap  [2];
  int                m_sent [2];
  bit                m_act  [2];
  bit                m_fin  [2];
  logic [FLIT_W-1:0] m_show [2];

  typedef struct {
    logic              rst_n, wr, cl, st, rdy;
    logic [FLIT_W-1:0] d;
    logic              ev;
    logic [FLIT_W-1:0] ed;
    logic [7:0]        es;
    logic              edn;
  } vec_t;

  vec_t              tbl [9];
  int                same_cnt, n_got, cyc;
  logic [6:0]        pat;
  logic [FLIT_W-1:0] exp4 [4];
  logic [FLIT_W-1:0] got  [4];

  function automatic int gapOf(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic void modelStep(input int k);
    if (!rst) begin
      m_cnt[k] = 0; m_act[k] = 0; m_fin[k] = 0; m_sent[k] = 0;
      m_gap[k] = 0; m_pos[k] = 0; m_show[k] = '0;
    end else if (!m_act[k]) begin
      if (clr) begin
        m_cnt[k] = 0;
        m_fin[k] = 0;
      end else if (start) begin
        if (m_cnt[k] > 0) begin
          m_act[k] = 1; m_fin[k] = 0; m_pos[k] = 0; m_sent[k] = 0;
          m_gap[k] = 0; m_show[k] = m_store[k][0];
        end
      end else if (wr_en && m_cnt[k] < 128) begin
        m_store[k][m_cnt[k]] = wr_data;
        m_cnt[k]++;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else if (out_ready) begin
      m_sent[k]++;
      if (m_sent[k] == m_cnt[k]) begin
        m_act[k] = 0;
        m_fin[k] = 1;
      end else begin
        m_pos[k]++;
        m_show[k] = m_store[k][m_pos[k]];
        m_gap[k]  = gapOf(k);
      end
    end
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("u%0d out_valid", k), 32'(ov[k]),
                  32'(m_act[k] && (m_gap[k] == 0)));
      checkOutput($sformatf("u%0d dataout", k), 32'(dout[k]), 32'(m_show[k]));
      checkOutput($sformatf("u%0d busy", k), 32'(bsy[k]), 32'(m_act[k]));
      checkOutput($sformatf("u%0d done", k), 32'(dn[k]), 32'(m_fin[k]));
      checkOutput($sformatf("u%0d sent", k), 32'(snt[k]), 32'(m_sent[k]));
    end
  endtask

  task automatic tick();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input logic r, input logic w,
                               input logic [FLIT_W-1:0] d, input logic c,
                               input logic s, input logic rdy);
    rst = r; wr_en = w; wr_data = d; clr = c; start = s; out_ready = rdy;
    tick();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadFlit(input logic [FLIT_W-1:0] d);
    applyStimulus(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; clr = 1'b0; start = 1'b0;
    out_ready = 1'b0;

    // Back-to-back table for the GAP=0 instance; expectations by hand.
    tbl[0] = '{rst_n:0, wr:0, cl:0, st:0, rdy:0, d:20'h0,     ev:0, ed:20'h0,     es:8'd0, edn:0};
    tbl[1] = '{rst_n:1, wr:1, cl:0, st:0, rdy:0, d:20'hABCD1, ev:0, ed:20'h0,     es:8'd0, edn:0};
    tbl[2] = '{rst_n:1, wr:1, cl:0, st:0, rdy:0, d:20'h12342, ev:0, ed:20'h0,     es:8'd0, edn:0};
    tbl[3] = '{rst_n:1, wr:1, cl:0, st:0, rdy:0, d:20'h0F0F3, ev:0, ed:20'h0,     es:8'd0, edn:0};
    tbl[4] = '{rst_n:1, wr:0, cl:0, st:1, rdy:1, d:20'h0,     ev:1, ed:20'hABCD1, es:8'd0, edn:0};
    tbl[5] = '{rst_n:1, wr:0, cl:0, st:0, rdy:1, d:20'h0,     ev:1, ed:20'h12342, es:8'd1, edn:0};
    tbl[6] = '{rst_n:1, wr:0, cl:0, st:0, rdy:1, d:20'h0,     ev:1, ed:20'h0F0F3, es:8'd2, edn:0};
    tbl[7] = '{rst_n:1, wr:0, cl:0, st:0, rdy:1, d:20'h0,     ev:0, ed:20'h0F0F3, es:8'd3, edn:1};
    tbl[8] = '{rst_n:1, wr:0, cl:0, st:0, rdy:1, d:20'h0,     ev:0, ed:20'h0F0F3, es:8'd3, edn:1};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].rst_n, tbl[i].wr, tbl[i].d, tbl[i].cl, tbl[i].st,
                    tbl[i].rdy);
      checkOutput($sformatf("tbl%0d out_valid", i), 32'(ov[0]), 32'(tbl[i].ev));
      checkOutput($sformatf("tbl%0d dataout", i), 32'(dout[0]), 32'(tbl[i].ed));
      checkOutput($sformatf("tbl%0d sent", i), 32'(snt[0]), 32'(tbl[i].es));
      checkOutput($sformatf("tbl%0d done", i), 32'(dn[0]), 32'(tbl[i].edn));
    end

    // Backpressure: ready low for four cycles after start.
    doReset();
    loadFlit(20'hABCD1);
    loadFlit(20'h12342);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    same_cnt = 0;
    if (ov[0] && dout[0] == 20'hABCD1) same_cnt++;
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b0);
      if (ov[0] && dout[0] == 20'hABCD1) same_cnt++;
      checkOutput("bp sent held", 32'(snt[0]), 32'd0);
    end
    checkOutput("bp hold cycles", 32'(same_cnt), 32'd5);
    idleCycle(1'b1);
    checkOutput("bp first hs sent", 32'(snt[0]), 32'd1);
    checkOutput("bp second flit", 32'(dout[0]), 32'h12342);
    idleCycle(1'b1);
    checkOutput("bp done", 32'(dn[0]), 32'd1);
    checkOutput("bp final sent", 32'(snt[0]), 32'd2);

    // Gap pattern on the GAP=2 instance.
    doReset();
    loadFlit(20'h11111);
    loadFlit(20'h22222);
    loadFlit(20'h33333);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    pat = {6'b0, ov[1]};
    for (int i = 0; i < 6; i++) begin
      idleCycle(1'b1);
      pat = {pat[5:0], ov[1]};
    end
    checkOutput("gap valid pattern", 32'(pat), 32'b1001001);
    idleCycle(1'b1);
    checkOutput("gap done", 32'(dn[1]), 32'd1);
    checkOutput("gap sent", 32'(snt[1]), 32'd3);

    // Capacity: 129 writes, then start+wr_en together.
    doReset();
    for (int i = 0; i < 129; i++) loadFlit(20'(i * 7 + 3));
    applyStimulus(1'b1, 1'b1, 20'hFFFFF, 1'b0, 1'b1, 1'b1);
    cyc = 0;
    while (!dn[0] && cyc < 200) begin
      idleCycle(1'b1);
      cyc++;
    end
    checkOutput("cap done", 32'(dn[0]), 32'd1);
    checkOutput("cap sent", 32'(snt[0]), 32'd128);
    checkOutput("cap last flit", 32'(dout[0]), 32'(127 * 7 + 3));
    cyc = 0;
    while (!dn[1] && cyc < 500) begin
      idleCycle(1'b1);
      cyc++;
    end
    checkOutput("cap gap done", 32'(dn[1]), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkOutput("clr+start done", 32'(dn[0]), 32'd0);
    checkOutput("clr+start busy", 32'(bsy[0]), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("empty start busy", 32'(bsy[0]), 32'd0);
    checkOutput("empty start valid", 32'(ov[0]), 32'd0);

    // Reset in the middle of a run.
    doReset();
    for (int i = 0; i < 10; i++) loadFlit(20'(32'h5A000 + i));
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idleCycle(1'b1);
    checkOutput("mid sent before rst", 32'(snt[0]), 32'd5);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid rst valid", 32'(ov[0]), 32'd0);
    checkOutput("mid rst sent", 32'(snt[0]), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid restart busy", 32'(bsy[0]), 32'd0);

    // Replay: start again from DONE.
    doReset();
    for (int i = 0; i < 4; i++) begin
      exp4[i] = 20'($urandom);
      loadFlit(exp4[i]);
    end
    for (int run = 0; run < 2; run++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("replay%0d sent start", run), 32'(snt[0]), 32'd0);
      n_got = 0;
      for (int c = 0; c < 20 && !dn[0]; c++) begin
        if (ov[0]) begin
          if (n_got < 4) got[n_got] = dout[0];
          n_got++;
        end
        idleCycle(1'b1);
      end
      checkOutput($sformatf("replay%0d count", run), 32'(n_got), 32'd4);
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("replay%0d flit%0d", run, i), 32'(got[i]),
                    32'(exp4[i]));
      checkOutput($sformatf("replay%0d sent end", run), 32'(snt[0]), 32'd4);
    end

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0,
                    20'($urandom), $urandom_range(0, 39) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dataout_buf.md
DATAOUT_BUF -- requirements
Module: dataout_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, giving the flit store depth in entries.
REQ-002 The block SHALL have parameter GAP, default 0, giving the idle cycles inserted after each accepted flit (injection-rate control, 0..255).
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on posedge clk only.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port wr_en, input, 1: load strobe for the flit store.
REQ-006 Port wr_data, input, 20: flit to load; [19:4] is the payload and [3:0] is the destination/control field.
REQ-007 Port clr, input, 1: pulse that empties the store count.
REQ-008 Port start, input, 1: pulse that begins transmission of all loaded flits.
REQ-009 Port out_ready, input, 1: downstream accept.
REQ-010 Port out_valid, output, 1: dataout holds a flit.
REQ-011 Port dataout, output, 20: registered flit, bit layout identical to wr_data.
REQ-012 Port busy, output, 1: high in SEND or GAP.
REQ-013 Port done, output, 1: high in DONE.
REQ-014 Port sent, output, 8: count of flits accepted in the current run.

Function
REQ-015 FSM states SHALL be IDLE, SEND, GAP and DONE; busy, done and out_valid SHALL be decoded from the state register.
REQ-016 In IDLE or DONE, wr_en with load_cnt<DEPTH SHALL write mem[load_cnt] and increment the 8-bit load_cnt; at load_cnt==DEPTH the write SHALL be dropped with no wrap.
REQ-017 wr_en SHALL be ignored in SEND and GAP.
REQ-018 clr in IDLE or DONE SHALL set load_cnt to 0 and the state to IDLE; clr SHALL be ignored in SEND and GAP.
REQ-019 Priority in the same cycle SHALL be clr > start > wr_en; a lower-priority request SHALL be dropped, not deferred.
REQ-020 start in IDLE or DONE with load_cnt>0 SHALL give SEND on the next cycle, with dataout=mem[0], rd_ptr=1 and sent=0.
REQ-021 start with load_cnt==0 SHALL leave the state unchanged.
REQ-022 In SEND, out_valid SHALL be 1 and dataout SHALL hold stable until a handshake (out_valid&&out_ready).
REQ-023 On a handshake, sent SHALL increment on the same edge.
REQ-024 On a handshake with sent+1==load_cnt, the next state SHALL be DONE.
REQ-025 On a handshake with flits remaining and GAP==0, the state SHALL stay SEND, dataout SHALL load mem[rd_ptr] and rd_ptr SHALL increment, giving back-to-back flits.
REQ-026 On a handshake with flits remaining and GAP>0, the state SHALL go to GAP with gap_cnt=GAP-1, and dataout SHALL load the next flit.
REQ-027 In GAP, out_valid SHALL be 0; gap_cnt SHALL decrement each cycle, and the state SHALL return to SEND in the cycle after gap_cnt==0.
REQ-028 A GAP run SHALL last exactly GAP cycles.
REQ-029 In DONE, out_valid SHALL be 0; sent SHALL hold its final value and mem SHALL be retained, so that start replays the same flits.
REQ-030 Latency from a start edge to the first out_valid high SHALL be 1 cycle.
REQ-031 With GAP=0 and out_ready held high, N flits SHALL take N consecutive cycles.

Reset
REQ-032 On rst==0 at a clock edge, the state SHALL become IDLE and out_valid, busy, done, sent, load_cnt, rd_ptr and gap_cnt SHALL become 0; dataout SHALL become 20'h00000.
REQ-033 Reset SHALL NOT clear mem; mem contents are don't-care after reset because load_cnt is 0.
REQ-034 A reset asserted mid-SEND SHALL drop out_valid on that edge with no partial handshake counted.

Structure
REQ-035 A shared package SHALL hold FLIT_W=20, PAYLOAD_MSB=19, PAYLOAD_LSB=4, the dest field [3:0], and the state encoding enum (IDLE=0, SEND=1, GAP=2, DONE=3); the sink buffers SHALL use the same flit constants.
REQ-036 The flit store SHALL be one sub-module, flit_ram (1 write port, 1 synchronous read port, DEPTH x FLIT_W); the FSM, counters and output register SHALL reside in dataout_buf.

Verification
REQ-037 Scenario, back-to-back: load 20'hABCD1, 20'h12342, 20'h0F0F3; start; out_ready=1; GAP=0 -> out_valid high for exactly 3 consecutive cycles starting 1 cycle after start, dataout in load order, sent=3, then done=1.
REQ-038 Scenario, backpressure: load 2 flits; out_ready=0 for 4 cycles after start, then 1 -> dataout stays 20'hABCD1 for 5 cycles, sent increments only on handshakes, done after 2 handshakes.
REQ-039 Scenario, gap: GAP=2, load 3 flits, out_ready=1 -> out_valid pattern 1,0,0,1,0,0,1, then done.
REQ-040 Scenario, capacity and priority: write 129 flits -> load_cnt=128 and the 129th is dropped; start+wr_en in the same cycle -> write dropped, transmission of 128 flits; clr+start -> IDLE, nothing sent.
REQ-041 Scenario, reset mid-send: assert rst after 5 of 10 flits sent -> next cycle out_valid=0, sent=0, load_cnt=0; start with no reload -> stays IDLE.
REQ-042 Scenario, replay: start in DONE -> identical flit sequence re-emitted, sent restarts at 0 and ends at load_cnt.
